// File: rtl/player_ctrl.sv
// Frame-rate player controller: cannon movement with clamping, edge-triggered
// fire over a req/ack handshake with cooldown, and the life/death state machine.
module player_ctrl #(
    parameter int          X_MIN         = 20,
    parameter int          X_MAX         = 600,
    parameter int          X_CENTER      = 320,
    parameter int          STEP          = 2,
    parameter int          GUN_OFFSET    = 13,
    parameter int          COOLDOWN      = 30,
    parameter int          DEATH_FRAMES  = 60,
    parameter int          INVULN_FRAMES = 120,
    parameter int          LIVES         = 3,
    parameter int          LIVES_W       = 2,
    parameter int          BLINK_BIT     = 3,
    parameter logic [7:0]  KEY_LEFT      = 8'h04,
    parameter logic [7:0]  KEY_RIGHT     = 8'h07,
    parameter logic [7:0]  KEY_FIRE      = 8'h2C
) (
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic [7:0]         keycode,
    input  logic               hit,
    input  logic               shot_ack,
    output logic [9:0]         player_X,
    output logic               shot_req,
    output logic [9:0]         shot_X,
    output logic [LIVES_W-1:0] lives,
    output logic [1:0]         player_state,
    output logic               visible,
    output logic               game_over
);

    typedef enum logic [1:0] {
        ST_ALIVE     = 2'd0,
        ST_DYING     = 2'd1,
        ST_RESPAWN   = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_e;

    localparam logic [9:0]         X_CENTER_V  = 10'(X_CENTER);
    localparam logic [9:0]         X_MIN_V     = 10'(X_MIN);
    localparam logic [9:0]         X_MAX_V     = 10'(X_MAX);
    localparam logic signed [10:0] X_MIN_S     = 11'(X_MIN);
    localparam logic [10:0]        X_MAX_U     = 11'(X_MAX);
    localparam logic signed [10:0] STEP_S      = 11'(STEP);
    localparam logic [10:0]        STEP_U      = 11'(STEP);
    localparam logic [9:0]         GUN_V       = 10'(GUN_OFFSET);
    localparam logic [7:0]         COOL_V      = 8'(COOLDOWN);
    localparam logic [7:0]         DEATH_INIT  = 8'(DEATH_FRAMES - 1);
    localparam logic [7:0]         INVULN_INIT = 8'(INVULN_FRAMES - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT  = LIVES_W'(LIVES);
    localparam logic [LIVES_W-1:0] LIVES_ONE   = LIVES_W'(1);

    state_e               state_q, state_d;
    logic [9:0]           x_q, x_d;
    logic                 req_q, req_d;
    logic [9:0]           shot_x_q, shot_x_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [7:0]           cool_q, cool_d;
    logic [7:0]           prev_key_q;
    logic                 visible_q, visible_d;
    logic                 game_over_q, game_over_d;

    logic                 active;
    logic                 fire_edge;
    logic signed [10:0]   x_left;
    logic [10:0]          x_right;

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q     <= ST_ALIVE;
            x_q         <= X_CENTER_V;
            req_q       <= 1'b0;
            shot_x_q    <= 10'd0;
            lives_q     <= LIVES_INIT;
            cnt_q       <= 8'd0;
            cool_q      <= 8'd0;
            prev_key_q  <= 8'd0;
            visible_q   <= 1'b1;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            req_q       <= req_d;
            shot_x_q    <= shot_x_d;
            lives_q     <= lives_d;
            cnt_q       <= cnt_d;
            cool_q      <= cool_d;
            prev_key_q  <= keycode;
            visible_q   <= visible_d;
            game_over_q <= game_over_d;
        end
    end

    // Shot handshake: shot_req rises on an accepted fire edge and stays high,
    // with shot_X stable, until an edge where shot_req and shot_ack are both 1.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        req_d       = req_q;
        shot_x_d    = shot_x_q;
        lives_d     = lives_q;
        cnt_d       = cnt_q;
        cool_d      = (cool_q != 8'd0) ? cool_q - 8'd1 : cool_q;
        visible_d   = 1'b1;
        game_over_d = 1'b0;

        active    = (state_q == ST_ALIVE) || (state_q == ST_RESPAWN);
        fire_edge = (keycode == KEY_FIRE) && (prev_key_q != KEY_FIRE);
        x_left    = $signed({1'b0, x_q}) - STEP_S;
        x_right   = {1'b0, x_q} + STEP_U;

        // Signed 11-bit arithmetic keeps a left step below zero from wrapping.
        if (active) begin
            if (keycode == KEY_LEFT) begin
                x_d = (x_left < X_MIN_S) ? X_MIN_V : x_left[9:0];
            end else if (keycode == KEY_RIGHT) begin
                x_d = (x_right > X_MAX_U) ? X_MAX_V : x_right[9:0];
            end
        end

        if (req_q && shot_ack) begin
            req_d  = 1'b0;
            cool_d = COOL_V;
        end else if (!req_q && fire_edge && active && (cool_q == 8'd0)) begin
            req_d    = 1'b1;
            shot_x_d = x_q + GUN_V;
        end

        case (state_q)
            ST_ALIVE: begin
                if (hit) begin
                    state_d = ST_DYING;
                    lives_d = lives_q - LIVES_ONE;
                    cnt_d   = DEATH_INIT;
                end
            end
            ST_DYING: begin
                if (cnt_q == 8'd0) begin
                    if (lives_q == '0) begin
                        state_d = ST_GAME_OVER;
                    end else begin
                        state_d = ST_RESPAWN;
                        x_d     = X_CENTER_V;
                        cnt_d   = INVULN_INIT;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_RESPAWN: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_ALIVE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = ST_GAME_OVER;
        endcase

        // Visibility follows the state and counter being entered so it stays registered.
        case (state_d)
            ST_RESPAWN:   visible_d = ~cnt_d[BLINK_BIT];
            ST_GAME_OVER: visible_d = 1'b0;
            default:      visible_d = 1'b1;
        endcase
        game_over_d = (state_d == ST_GAME_OVER);
    end

    assign player_X     = x_q;
    assign shot_req     = req_q;
    assign shot_X       = shot_x_q;
    assign lives        = lives_q;
    assign player_state = state_q;
    assign visible      = visible_q;
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Bench for player_ctrl: vector table, directed multi-frame sequences and
// randomized frames, all checked against a frame-level reference model.
module tb_player_ctrl;

  localparam int         X_MIN = 20, X_MAX = 600, X_CENTER = 320, STEP = 2;
  localparam int         GUN = 13, COOLDOWN = 30, DEATH = 60, INVULN = 120;
  localparam int         LIVES = 3, BLINK = 3;
  localparam logic [7:0] K_L = 8'h04, K_R = 8'h07, K_F = 8'h2C;

  // clock / reset block
  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] keycode = 8'd0;
  logic       hit = 1'b0;
  logic       shot_ack = 1'b0;
  logic [9:0] player_X, shot_X;
  logic       shot_req, visible, game_over;
  logic [1:0] lives, player_state;

  always #5 frame_clk = ~frame_clk;

  player_ctrl #(
    .X_MIN(X_MIN), .X_MAX(X_MAX), .X_CENTER(X_CENTER), .STEP(STEP),
    .GUN_OFFSET(GUN), .COOLDOWN(COOLDOWN), .DEATH_FRAMES(DEATH),
    .INVULN_FRAMES(INVULN), .LIVES(LIVES), .LIVES_W(2), .BLINK_BIT(BLINK),
    .KEY_LEFT(K_L), .KEY_RIGHT(K_R), .KEY_FIRE(K_F)
  ) dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .hit(hit),
    .shot_ack(shot_ack), .player_X(player_X), .shot_req(shot_req),
    .shot_X(shot_X), .lives(lives), .player_state(player_state),
    .visible(visible), .game_over(game_over)
  );

  // scoreboard
  int n_checks = 0;
  int n_fails = 0;
  int n_cycle = 0;
  logic [26:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference model: whole frames, phases tracked as frames remaining
  int m_x, m_req, m_sx, m_lives, m_state, m_left, m_cool, m_prev, m_vis;

  function automatic void model_frame(input logic rst, input int key,
                                      input logic h, input logic a);
    bit active, fire_edge, accept, take_ack;
    int ox;
    if (rst) begin
      m_x = X_CENTER; m_req = 0; m_sx = 0; m_lives = LIVES; m_state = 0;
      m_left = 0; m_cool = 0; m_prev = 0;
    end else begin
      ox        = m_x;
      active    = (m_state == 0) || (m_state == 2);
      fire_edge = (key == K_F) && (m_prev != K_F);
      m_prev    = key;
      take_ack  = (m_req == 1) && a;
      accept    = (m_req == 0) && fire_edge && active && (m_cool == 0);
      if (m_cool > 0) m_cool--;
      if (take_ack) begin
        m_req = 0;
        m_cool = COOLDOWN;
      end
      if (accept) begin
        m_req = 1;
        m_sx = (ox + GUN) % 1024;
      end
      if (active && key == K_L) m_x = (ox - STEP < X_MIN) ? X_MIN : ox - STEP;
      if (active && key == K_R) m_x = (ox + STEP > X_MAX) ? X_MAX : ox + STEP;
      case (m_state)
        0: if (h) begin m_state = 1; m_lives--; m_left = DEATH; end
        1: begin
          if (m_left == 1) begin
            if (m_lives == 0) m_state = 3;
            else begin m_state = 2; m_x = X_CENTER; m_left = INVULN; end
          end else m_left--;
        end
        2: if (m_left == 1) m_state = 0; else m_left--;
        default: ;
      endcase
    end
    // visible during respawn blinks from the frames still to go in that phase
    case (m_state)
      2: m_vis = (((m_left - 1) >> BLINK) & 1) == 0 ? 1 : 0;
      3: m_vis = 0;
      default: m_vis = 1;
    endcase
    exp_q.push_back({10'(m_x), 1'(m_req), 10'(m_sx), 2'(m_lives), 2'(m_state),
                     1'(m_vis), 1'(m_state == 3)});
  endfunction

  // driver: apply one frame of inputs, advance one edge, compare with model
  task automatic step(input logic rst, input logic [7:0] key, input logic h,
                      input logic a);
    logic [26:0] exp, act;
    Reset = rst; keycode = key; hit = h; shot_ack = a;
    model_frame(rst, key, h, a);
    @(posedge frame_clk);
    #1;
    n_cycle++;
    exp = exp_q.pop_front();
    act = {player_X, shot_req, shot_X, lives, player_state, visible, game_over};
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL model_cycle%0d: got %h expected %h", n_cycle, act, exp);
    end
  endtask

  task automatic do_reset();
    step(1'b1, 8'd0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [7:0] key;
    logic       h;
    logic       a;
    int         x, req, sx, lv, st;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int cnt, tog, pv;
    tbl[0] = '{K_R,   1'b0, 1'b0, 322, 0, 0,   3, 0};
    tbl[1] = '{K_R,   1'b0, 1'b0, 324, 0, 0,   3, 0};
    tbl[2] = '{K_L,   1'b0, 1'b0, 322, 0, 0,   3, 0};
    tbl[3] = '{K_F,   1'b0, 1'b0, 322, 1, 335, 3, 0};
    tbl[4] = '{K_F,   1'b0, 1'b1, 322, 0, 335, 3, 0};
    tbl[5] = '{8'h00, 1'b0, 1'b0, 322, 0, 335, 3, 0};
    tbl[6] = '{K_F,   1'b0, 1'b0, 322, 0, 335, 3, 0};
    tbl[7] = '{8'h00, 1'b1, 1'b0, 322, 0, 335, 2, 1};
    tbl[8] = '{K_R,   1'b0, 1'b0, 322, 0, 335, 2, 1};
    tbl[9] = '{K_F,   1'b0, 1'b0, 322, 0, 335, 2, 1};

    // reset state
    do_reset();
    chk("rst_x", player_X, X_CENTER);
    chk("rst_req", shot_req, 0);
    chk("rst_shot_x", shot_X, 0);
    chk("rst_lives", lives, LIVES);
    chk("rst_state", player_state, 0);
    chk("rst_visible", visible, 1);
    chk("rst_game_over", game_over, 0);

    // vector table
    for (int i = 0; i < 10; i++) begin
      step(1'b0, tbl[i].key, tbl[i].h, tbl[i].a);
      chk($sformatf("tbl%0d_x", i), player_X, tbl[i].x);
      chk($sformatf("tbl%0d_req", i), shot_req, tbl[i].req);
      chk($sformatf("tbl%0d_sx", i), shot_X, tbl[i].sx);
      chk($sformatf("tbl%0d_lives", i), lives, tbl[i].lv);
      chk($sformatf("tbl%0d_state", i), player_state, tbl[i].st);
    end

    // right clamp
    do_reset();
    for (int i = 0; i < 141; i++) begin
      step(1'b0, K_R, 1'b0, 1'b0);
      if (i == 0) chk("right_first", player_X, 322);
    end
    chk("right_clamp", player_X, X_MAX);

    // left clamp
    for (int i = 0; i < 300; i++) step(1'b0, K_L, 1'b0, 1'b0);
    chk("left_clamp", player_X, X_MIN);
    step(1'b0, K_L, 1'b0, 1'b0);
    chk("left_clamp_again", player_X, X_MIN);

    // fire, ack, hold, cooldown
    do_reset();
    step(1'b0, K_F, 1'b0, 1'b0);
    chk("fire_req", shot_req, 1);
    chk("fire_shot_x", shot_X, 333);
    step(1'b0, K_F, 1'b0, 1'b0);
    chk("fire_held_req", shot_req, 1);
    step(1'b0, K_F, 1'b0, 1'b1);
    chk("fire_acked", shot_req, 0);
    for (int i = 0; i < 7; i++) step(1'b0, K_F, 1'b0, 1'b0);
    chk("fire_hold_no_refire", shot_req, 0);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b0, K_F, 1'b0, 1'b0);
    chk("fire_in_cooldown", shot_req, 0);
    for (int i = 0; i < 30; i++) step(1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b0, K_F, 1'b0, 1'b0);
    chk("fire_after_cooldown", shot_req, 1);
    chk("fire_after_cooldown_x", shot_X, 333);

    // death and respawn
    do_reset();
    step(1'b0, 8'd0, 1'b1, 1'b1);
    chk("hit_lives", lives, 2);
    chk("hit_state", player_state, 1);
    cnt = 1;
    for (int i = 0; i < 200 && player_state == 2'd1; i++) begin
      step(1'b0, K_R, 1'b0, 1'b0);
      if (player_state == 2'd1) cnt++;
    end
    chk("dying_frames", cnt, DEATH);
    chk("respawn_state", player_state, 2);
    chk("respawn_x", player_X, X_CENTER);
    cnt = 1; tog = 0; pv = visible;
    for (int i = 0; i < 300 && player_state == 2'd2; i++) begin
      step(1'b0, 8'd0, (i % 10) == 5, 1'b0);
      if (player_state == 2'd2) begin
        cnt++;
        if (visible != pv) tog++;
        pv = visible;
      end
    end
    chk("respawn_frames", cnt, INVULN);
    chk("respawn_toggles", tog, 14);
    chk("respawn_lives", lives, 2);
    chk("back_alive", player_state, 0);

    // game over after three hits
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 8'd0, 1'b1, 1'b0);
      for (int i = 0; i < 400 && player_state inside {2'd1, 2'd2}; i++)
        step(1'b0, 8'd0, 1'b0, 1'b0);
    end
    chk("go_state", player_state, 3);
    chk("go_flag", game_over, 1);
    chk("go_visible", visible, 0);
    chk("go_lives", lives, 0);
    for (int i = 0; i < 6; i++) step(1'b0, (i % 2) ? K_F : K_R, 1'b0, 1'b0);
    chk("go_keys_x", player_X, X_CENTER);
    chk("go_keys_req", shot_req, 0);

    // reset during dying with a request pending
    do_reset();
    step(1'b0, K_F, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, K_L, 1'b0, 1'b0);
    chk("pend_survives_hit", shot_req, 1);
    chk("pend_dying", player_state, 1);
    do_reset();
    chk("mid_rst_state", player_state, 0);
    chk("mid_rst_lives", lives, LIVES);
    chk("mid_rst_x", player_X, X_CENTER);
    chk("mid_rst_req", shot_req, 0);

    // randomized frames
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] k;
      case ($urandom_range(0, 5))
        0: k = K_L;
        1, 2: k = K_R;
        3: k = K_F;
        4: k = 8'd0;
        default: k = 8'($urandom_range(0, 255));
      endcase
      if ((i % 700) == 699) do_reset();
      else step(1'b0, k, $urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
